// File: rtl/lsu_bus_reader.sv
// Load/store bus sequencer: word bus handshake, lane steering, load extension.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_bus_reader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Fault
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      state_q;
  size_t       sz_q;
  logic        sext_q;
  logic [1:0]  lo_q;
  logic [15:0] cnt_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        fault_q;

  size_t       sz_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        mis_d;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  always_comb begin
    sz_d = SZ_W;
    if (MemWrite) begin
      case (Funct3)
        3'b000:  sz_d = SZ_B;
        3'b001:  sz_d = SZ_H;
        default: sz_d = SZ_W;
      endcase
    end else begin
      case (Funct3)
        3'b000, 3'b100: sz_d = SZ_B;
        3'b001, 3'b101: sz_d = SZ_H;
        default:        sz_d = SZ_W;
      endcase
    end
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (MemWrite) begin
      case (sz_d)
        SZ_B: begin
          be_d    = 4'b0001 << ALUResult[1:0];
          wdata_d = {4{WriteData[7:0]}};
        end
        SZ_H: begin
          be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{WriteData[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = WriteData;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_d = ((sz_d == SZ_H) && ALUResult[0]) ||
                 ((sz_d == SZ_W) && (ALUResult[1:0] != 2'b00));
`else
  assign mis_d = 1'b0;
`endif

  always_comb begin
    case (lo_q)
      2'd0:    ld_b = bus_rdata[7:0];
      2'd1:    ld_b = bus_rdata[15:8];
      2'd2:    ld_b = bus_rdata[23:16];
      default: ld_b = bus_rdata[31:24];
    endcase
    ld_h = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (sz_q)
      SZ_B:    ld_val = {{24{sext_q & ld_b[7]}}, ld_b};
      SZ_H:    ld_val = {{16{sext_q & ld_h[15]}}, ld_h};
      default: ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sz_q    <= SZ_W;
      sext_q  <= 1'b0;
      lo_q    <= 2'b00;
      cnt_q   <= 16'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          cnt_q   <= 16'h0;
          if (MemReq) begin
            if (mis_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              if (!MemWrite) rdata_q <= 32'h0;
            end else begin
              state_q <= S_BUS;
              req_q   <= 1'b1;
              we_q    <= MemWrite;
              addr_q  <= {ALUResult[31:2], 2'b00};
              wdata_q <= wdata_d;
              be_q    <= be_d;
              sz_q    <= sz_d;
              sext_q  <= ~Funct3[2];
              lo_q    <= ALUResult[1:0];
            end
          end
        end
        S_BUS: begin
          // ack is checked first so it beats a simultaneous timeout
          if (bus_ack || (cnt_q == TMAX)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fault_q <= ~bus_ack;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            cnt_q   <= 16'h0;
            if (!we_q) rdata_q <= bus_ack ? ld_val : 32'h0;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Stall = ~reset &
                 (((state_q == S_IDLE) & MemReq) | (state_q == S_BUS));

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign ReadData  = rdata_q;
  assign Done      = done_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_lsu_bus_reader.sv
// Directed bench for lsu_bus_reader with TIMEOUT = 4.
// Covers loads, stores, wait states, timeout, misalignment and reset abort.
module tb_lsu_bus_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        Stall;
  logic [31:0] ReadData;
  logic        Done;
  logic        Fault;

  int n_run  = 0;
  int n_fail = 0;

  int          o_stall;
  int          o_reqn;
  logic        o_stable;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic        o_we;
  logic        o_done;
  logic        o_fault;
  logic [31:0] o_rd;
  logic        o_dstall;
  logic        o_done2;

  lsu_bus_reader #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemReq(MemReq), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult),
    .WriteData(WriteData),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .Stall(Stall),
    .ReadData(ReadData), .Done(Done),
    .Fault(Fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int dly);
    cyc();
    MemReq = 1'b1; MemWrite = we; Funct3 = f3;
    ALUResult = a; WriteData = wd; bus_ack = 1'b0;
    #1;
    o_stall = Stall ? 1 : 0;
    o_reqn = 0; o_stable = 1'b1;
    o_addr = 'x; o_be = 'x; o_wdata = 'x; o_we = 1'bx;
    o_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      bus_ack = 1'b0;
      #1;
      if (Done) begin
        o_done = 1'b1;
        break;
      end
      if (Stall) o_stall++;
      if (bus_req) begin
        if (o_reqn == 0) begin
          o_addr = bus_addr; o_be = bus_be;
          o_wdata = bus_wdata; o_we = bus_we;
        end else if (bus_addr !== o_addr || bus_be !== o_be ||
                     bus_wdata !== o_wdata || bus_we !== o_we) begin
          o_stable = 1'b0;
        end
        o_reqn++;
      end
      bus_rdata = rd;
      bus_ack = (n == dly);
    end
    o_fault  = Fault;
    o_rd     = ReadData;
    o_dstall = Stall;
    cyc();
    MemReq = 1'b0; bus_ack = 1'b0;
    #1;
    o_done2 = Done;
  endtask

  initial begin
    reset = 1'b1; MemReq = 1'b1; MemWrite = 1'b0;
    Funct3 = 3'b010; ALUResult = 32'h0; WriteData = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    cyc(); cyc(); #1;
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_be", {28'b0, bus_be}, 32'h0);
    chk("rst_rd", ReadData, 32'h0);
    chk("rst_done", {31'b0, Done}, 32'h0);
    chk("rst_fault", {31'b0, Fault}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    cyc(); reset = 1'b0; MemReq = 1'b0;

    // LW, ack in first BUS cycle
    txn(1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_addr", o_addr, 32'h0000_1004);
    chk("lw_be", {28'b0, o_be}, 32'hF);
    chk("lw_we", {31'b0, o_we}, 32'h0);
    chk("lw_stall", o_stall, 2);
    chk("lw_done", {31'b0, o_done}, 32'h1);
    chk("lw_dstall", {31'b0, o_dstall}, 32'h0);
    chk("lw_rd", o_rd, 32'hDEAD_BEEF);
    chk("lw_fault", {31'b0, o_fault}, 32'h0);
    chk("lw_done2", {31'b0, o_done2}, 32'h0);

    txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
    chk("lb_rd", o_rd, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
    chk("lbu_rd", o_rd, 32'h0000_0080);

    txn(1'b1, 3'b001, 32'h0000_0106, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
    chk("sh_we", {31'b0, o_we}, 32'h1);
    chk("sh_be", {28'b0, o_be}, 32'hC);
    chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
    chk("sh_addr", o_addr, 32'h0000_0104);
    chk("sh_rd", o_rd, 32'h0000_0080);

    txn(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0);
    chk("sb_be", {28'b0, o_be}, 32'h2);
    chk("sb_wdata", o_wdata, 32'hA5A5_A5A5);

    txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0);
    chk("lh_rd", o_rd, 32'hFFFF_8001);
    txn(1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h8001_F00F, 0);
    chk("lhu_rd", o_rd, 32'h0000_F00F);

    // ack lands in the last BUS cycle before timeout: ack wins
    txn(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1122_3344, 3);
    chk("wait_stall", o_stall, 5);
    chk("wait_reqn", o_reqn, 4);
    chk("wait_stable", {31'b0, o_stable}, 32'h1);
    chk("wait_addr", o_addr, 32'h0000_2000);
    chk("wait_rd", o_rd, 32'h1122_3344);
    chk("wait_fault", {31'b0, o_fault}, 32'h0);

    txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h5555_5555, 1000);
    chk("to_done", {31'b0, o_done}, 32'h1);
    chk("to_fault", {31'b0, o_fault}, 32'h1);
    chk("to_rd", o_rd, 32'h0);
    chk("to_reqn", o_reqn, 4);

    txn(1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_reqn", o_reqn, 0);
    chk("mis_fault", {31'b0, o_fault}, 32'h1);
    chk("mis_rd", o_rd, 32'h0);
    chk("mis_stall", o_stall, 1);
`else
    chk("mis_addr", o_addr, 32'h0000_1000);
    chk("mis_fault", {31'b0, o_fault}, 32'h0);
    chk("mis_rd", o_rd, 32'hCAFE_F00D);
    chk("mis_stall", o_stall, 2);
`endif
    chk("mis_done", {31'b0, o_done}, 32'h1);

    // reset in second BUS cycle
    cyc();
    MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    ALUResult = 32'h0000_5000; bus_ack = 1'b0;
    cyc();
    #1;
    chk("ra_req1", {31'b0, bus_req}, 32'h1);
    cyc();
    reset = 1'b1;
    cyc();
    #1;
    chk("ra_req", {31'b0, bus_req}, 32'h0);
    chk("ra_done", {31'b0, Done}, 32'h0);
    chk("ra_stall", {31'b0, Stall}, 32'h0);
    reset = 1'b0; MemReq = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    cyc();
    bus_ack = 1'b0;
    #1;
    chk("ra_late_done", {31'b0, Done}, 32'h0);
    chk("ra_late_req", {31'b0, bus_req}, 32'h0);
    chk("ra_rd", ReadData, 32'h0);

    txn(1'b1, 3'b010, 32'h0000_4008, 32'h55AA_1234, 32'h0, 0);
    chk("sw_be", {28'b0, o_be}, 32'hF);
    chk("sw_wdata", o_wdata, 32'h55AA_1234);
    chk("sw_done", {31'b0, o_done}, 32'h1);
    chk("sw_fault", {31'b0, o_fault}, 32'h0);
    chk("sw_stall", o_stall, 2);
    chk("sw_rd", o_rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
